// File: rtl/msf_encoder.sv
// MSF time-signal carrier envelope encoder: one second is ten 100 ms slots,
// and the content for each second is accepted over a ready/valid handshake at the second boundary.
module msf_encoder #(
  parameter int CLK_FREQ = 12500
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       sec_valid_i,
  input  logic       minute_mark_i,
  input  logic       bit_a_i,
  input  logic       bit_b_i,
  output logic       sec_ready_o,
  output logic       data_o,
  output logic       second_start_o,
  output logic [3:0] slot_o,
  output logic       busy_o,
  output logic       underrun_o
);

  localparam int COUNT_FULL = CLK_FREQ / 10;
  localparam int CNT_W      = $clog2(COUNT_FULL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_FULL - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic [3:0]       r_slot, w_slot_next;
  logic             r_data, w_data_next;
  logic             r_mark, w_mark_next;
  logic             r_a, w_a_next;
  logic             r_b, w_b_next;
  logic             r_second_start, w_second_start_next;
  logic             r_underrun, w_underrun_next;
  logic             w_boundary;

  // Carrier level for a given slot of the latched second.
  function automatic logic slot_level(input logic mark, input logic a,
                                      input logic b, input logic [3:0] slot);
    if (mark) return (slot >= 4'd5);
    case (slot)
      4'd0:    return 1'b0;
      4'd1:    return ~a;
      4'd2:    return ~b;
      default: return 1'b1;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_slot         <= 4'd0;
      r_data         <= 1'b1;
      r_mark         <= 1'b0;
      r_a            <= 1'b0;
      r_b            <= 1'b0;
      r_second_start <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_count        <= w_count_next;
      r_slot         <= w_slot_next;
      r_data         <= w_data_next;
      r_mark         <= w_mark_next;
      r_a            <= w_a_next;
      r_b            <= w_b_next;
      r_second_start <= w_second_start_next;
      r_underrun     <= w_underrun_next;
    end
  end

  always_comb begin
    w_boundary = ((r_state == S_IDLE) && enable_i) ||
                 ((r_state == S_RUN) && (r_slot == 4'd9) && (r_count == CNT_LAST));

    w_state_next        = r_state;
    w_count_next        = r_count;
    w_slot_next         = r_slot;
    w_data_next         = r_data;
    w_mark_next         = r_mark;
    w_a_next            = r_a;
    w_b_next            = r_b;
    w_second_start_next = 1'b0;
    w_underrun_next     = 1'b0;

    if (!enable_i) begin
      // Disabling abandons the second in progress without flagging an underrun.
      w_state_next = S_IDLE;
      w_count_next = '0;
      w_slot_next  = 4'd0;
      w_data_next  = 1'b1;
      w_mark_next  = 1'b0;
      w_a_next     = 1'b0;
      w_b_next     = 1'b0;
    end else if (w_boundary) begin
      w_state_next        = S_RUN;
      w_count_next        = '0;
      w_slot_next         = 4'd0;
      w_mark_next         = sec_valid_i & minute_mark_i;
      w_a_next            = sec_valid_i & bit_a_i;
      w_b_next            = sec_valid_i & bit_b_i;
      w_data_next         = 1'b0;
      w_second_start_next = 1'b1;
      w_underrun_next     = ~sec_valid_i;
    end else if (r_count == CNT_LAST) begin
      w_count_next = '0;
      w_slot_next  = r_slot + 4'd1;
      w_data_next  = slot_level(r_mark, r_a, r_b, r_slot + 4'd1);
    end else begin
      w_count_next = r_count + 1'b1;
    end
  end

  // Gated by rst_ni so the strobe drops immediately during reset.
  assign sec_ready_o    = w_boundary & enable_i & rst_ni;
  assign data_o         = r_data;
  assign second_start_o = r_second_start;
  assign slot_o         = r_slot;
  assign busy_o         = (r_state == S_RUN);
  assign underrun_o     = r_underrun;

endmodule
